// File: rtl/id_ex_stage_pkg.sv
// Shared ALU encodings for the ID/EX stage and the ALU.
// Covers ALUOp codes, R-type funct codes and the 4-bit ALU control codes.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ORI   = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    // Control fields carried through the ID/EX register.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       illegal;
        logic       alu_src;
        logic [3:0] control;
    } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_alu_ctrl.sv
// Combinational ALUOp/funct decode into the ALU control code.
// Flags unsupported R-type funct values as illegal.
module alu_ctrl
    import id_ex_stage_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] control,
    output logic       illegal
);

    always_comb begin
        control = ALU_ADD;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: control = ALU_ADD;
            ALUOP_SUB: control = ALU_SUB;
            ALUOP_ORI: control = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: control = ALU_ADD;
                    FUNCT_SUB: control = ALU_SUB;
                    FUNCT_AND: control = ALU_AND;
                    FUNCT_OR:  control = ALU_OR;
                    FUNCT_SLT: control = ALU_SLT;
                    FUNCT_NOR: control = ALU_NOR;
                    default:   illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Feeds ALU operands and control one cycle after ID capture.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [WIDTH-1:0]      id_rs_data,
    input  logic [WIDTH-1:0]      id_rt_data,
    input  logic [15:0]           id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [1:0]            id_alu_op,
    input  logic [5:0]            id_funct,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic                  id_reg_write,
    input  logic                  exmem_reg_write,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [WIDTH-1:0]      exmem_result,
    input  logic [WIDTH-1:0]      memwb_result,
    output logic [WIDTH-1:0]      alu_left,
    output logic [WIDTH-1:0]      alu_right,
    output logic [3:0]            alu_control,
    output logic [WIDTH-1:0]      ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  ex_reg_write,
    output logic                  ex_valid,
    output logic                  ex_illegal
);

    logic [3:0]            dec_control;
    logic                  dec_illegal;
    logic [WIDTH-1:0]      imm_ext;

    ex_ctrl_t              ctrl_q;
    logic [WIDTH-1:0]      rs_data_q, rt_data_q, imm_q;
    logic [REG_ADDR_W-1:0] rs_q, rt_q, dest_q;

    logic                  exmem_hit_rs, memwb_hit_rs, exmem_hit_rt, memwb_hit_rt;
    logic [WIDTH-1:0]      fwd_rs, fwd_rt;

    alu_ctrl u_alu_ctrl (
        .alu_op  (id_alu_op),
        .funct   (id_funct),
        .control (dec_control),
        .illegal (dec_illegal)
    );

    // ORI uses a logical immediate; everything else is arithmetic.
    assign imm_ext = (id_alu_op == ALUOP_ORI) ? {{(WIDTH-16){1'b0}}, id_imm}
                                              : {{(WIDTH-16){id_imm[15]}}, id_imm};

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
        end else if (flush) begin
            ctrl_q    <= '{valid: 1'b0, reg_write: 1'b0, illegal: 1'b0,
                           alu_src: 1'b0, control: ALU_ADD};
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
        end else if (!stall) begin
            ctrl_q.valid     <= id_valid;
            ctrl_q.reg_write <= id_reg_write & id_valid & ~dec_illegal;
            ctrl_q.illegal   <= dec_illegal & id_valid;
            ctrl_q.alu_src   <= id_alu_src;
            ctrl_q.control   <= dec_control;
            rs_data_q        <= id_rs_data;
            rt_data_q        <= id_rt_data;
            imm_q            <= imm_ext;
            rs_q             <= id_rs;
            rt_q             <= id_rt;
            dest_q           <= id_reg_dst ? id_rd : id_rt;
        end
    end

    // Nearest producer wins; r0 is hard-wired so it is never forwarded.
    assign exmem_hit_rs = exmem_reg_write && (exmem_rd == rs_q) && (rs_q != '0);
    assign memwb_hit_rs = memwb_reg_write && (memwb_rd == rs_q) && (rs_q != '0);
    assign exmem_hit_rt = exmem_reg_write && (exmem_rd == rt_q) && (rt_q != '0);
    assign memwb_hit_rt = memwb_reg_write && (memwb_rd == rt_q) && (rt_q != '0);

    assign fwd_rs = exmem_hit_rs ? exmem_result : memwb_hit_rs ? memwb_result : rs_data_q;
    assign fwd_rt = exmem_hit_rt ? exmem_result : memwb_hit_rt ? memwb_result : rt_data_q;

    assign alu_left      = fwd_rs;
    assign alu_right     = ctrl_q.alu_src ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_control   = ctrl_q.control;
    assign ex_dest       = dest_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_valid      = ctrl_q.valid;
    assign ex_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: decode, immediates, forwarding,
// stall/flush/reset priority, with hand-computed expectations.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src, id_reg_dst, id_reg_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_left, alu_right, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_valid, ex_illegal;

    int checks = 0;
    int errors = 0;

    logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    logic [3:0] cc_tab [6] = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b1100};

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_funct(id_funct), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .exmem_reg_write(exmem_reg_write),
        .memwb_reg_write(memwb_reg_write), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .alu_left(alu_left), .alu_right(alu_right), .alu_control(alu_control),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_valid(ex_valid), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic src, input logic dst, input logic rw,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm);
        id_valid = v;  id_alu_op = op;  id_funct = fn;  id_alu_src = src;
        id_reg_dst = dst;  id_reg_write = rw;  id_rs = rs;  id_rt = rt;  id_rd = rd;
        id_rs_data = a;  id_rt_data = b;  id_imm = imm;
    endtask

    task automatic no_fwd();
        exmem_reg_write = 1'b0;  memwb_reg_write = 1'b0;
        exmem_rd = '0;  memwb_rd = '0;  exmem_result = '0;  memwb_result = '0;
    endtask

    initial begin
        stall = 1'b0;  flush = 1'b0;  reset = 1'b1;
        no_fwd();
        issue(1'b1, 2'($urandom), 6'($urandom), 1'b1, 1'b1, 1'b1, 5'($urandom), 5'($urandom),
              5'($urandom), $urandom, $urandom, 16'($urandom));
        step();
        issue(1'b1, 2'($urandom), 6'($urandom), 1'b1, 1'b0, 1'b1, 5'($urandom), 5'($urandom),
              5'($urandom), $urandom, $urandom, 16'($urandom));
        step();
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_rw", 32'(ex_reg_write), 0);
        chk("rst_ill", 32'(ex_illegal), 0);
        chk("rst_dest", 32'(ex_dest), 0);
        chk("rst_ctrl", 32'(alu_control), 0);
        chk("rst_left", alu_left, 0);
        chk("rst_right", alu_right, 0);
        chk("rst_store", ex_store_data, 0);
        reset = 1'b0;

        // R-type sub r5 = r3 - r4
        issue(1'b1, 2'b10, 6'b100010, 1'b0, 1'b1, 1'b1, 5'd3, 5'd4, 5'd5, 32'd10, 32'd3, 16'h0);
        step();
        chk("sub_left", alu_left, 32'd10);
        chk("sub_right", alu_right, 32'd3);
        chk("sub_ctrl", 32'(alu_control), 32'h6);
        chk("sub_dest", 32'(ex_dest), 32'd5);
        chk("sub_rw", 32'(ex_reg_write), 1);
        chk("sub_valid", 32'(ex_valid), 1);
        chk("sub_store", ex_store_data, 32'd3);

        // forwarding on the held instruction (rs=3, rt=4)
        exmem_reg_write = 1'b1;  exmem_rd = 5'd3;  exmem_result = 32'h55;
        memwb_reg_write = 1'b1;  memwb_rd = 5'd3;  memwb_result = 32'h66;
        #1 chk("fwd_both", alu_left, 32'h55);
        chk("fwd_rt_none", alu_right, 32'd3);
        exmem_reg_write = 1'b0;
        #1 chk("fwd_memwb", alu_left, 32'h66);
        memwb_rd = 5'd4;
        #1 chk("fwd_rt_left", alu_left, 32'd10);
        chk("fwd_rt_right", alu_right, 32'h66);
        chk("fwd_rt_store", ex_store_data, 32'h66);
        exmem_reg_write = 1'b1;  exmem_rd = 5'd4;
        #1 chk("fwd_rt_exmem", ex_store_data, 32'h55);
        no_fwd();

        // r0 never forwarded
        issue(1'b1, 2'b10, 6'b100000, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd6, 32'd7, 32'd9, 16'h0);
        step();
        exmem_reg_write = 1'b1;  exmem_result = 32'h55;
        memwb_reg_write = 1'b1;  memwb_result = 32'h66;
        #1 chk("r0_left", alu_left, 32'd7);
        chk("r0_right", alu_right, 32'd9);
        no_fwd();

        // immediates
        issue(1'b1, 2'b11, 6'b0, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 16'hFFFF);
        step();
        chk("ori_right", alu_right, 32'h0000FFFF);
        chk("ori_ctrl", 32'(alu_control), 32'h1);
        chk("ori_dest", 32'(ex_dest), 32'd2);
        chk("ori_store", ex_store_data, 32'd2);
        issue(1'b1, 2'b00, 6'b0, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 16'hFFFF);
        step();
        chk("addi_right", alu_right, 32'hFFFFFFFF);
        chk("addi_ctrl", 32'(alu_control), 32'h2);
        issue(1'b1, 2'b01, 6'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 16'h7FFF);
        step();
        chk("aluop01_ctrl", 32'(alu_control), 32'h6);
        chk("aluop01_right", alu_right, 32'd2);

        // R-type funct decode table
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, 2'b10, fn_tab[i], 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0);
            step();
            chk($sformatf("funct_%0d_ctrl", i), 32'(alu_control), 32'(cc_tab[i]));
            chk($sformatf("funct_%0d_ill", i), 32'(ex_illegal), 0);
        end

        // stall holds while ID changes
        issue(1'b1, 2'b10, 6'b100000, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd7, 32'h11, 32'h22, 16'h0);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 2'b01, 6'b0, 1'b1, 1'b0, 1'b0, 5'd9, 5'd8, 5'd10,
                  32'h99 + i, 32'h88 + i, 16'h8000);
            step();
            chk($sformatf("stall_%0d_left", i), alu_left, 32'h11);
            chk($sformatf("stall_%0d_right", i), alu_right, 32'h22);
            chk($sformatf("stall_%0d_ctrl", i), 32'(alu_control), 32'h2);
            chk($sformatf("stall_%0d_dest", i), 32'(ex_dest), 32'd7);
        end
        flush = 1'b1;
        step();
        chk("flush_valid", 32'(ex_valid), 0);
        chk("flush_rw", 32'(ex_reg_write), 0);
        chk("flush_ctrl", 32'(alu_control), 32'h2);
        chk("flush_left", alu_left, 0);
        chk("flush_dest", 32'(ex_dest), 0);
        flush = 1'b0;  stall = 1'b0;

        // unsupported funct
        issue(1'b1, 2'b10, 6'b000000, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0);
        step();
        chk("ill_flag", 32'(ex_illegal), 1);
        chk("ill_ctrl", 32'(alu_control), 32'h2);
        chk("ill_rw", 32'(ex_reg_write), 0);
        chk("ill_valid", 32'(ex_valid), 1);
        issue(1'b0, 2'b10, 6'b000000, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0);
        step();
        chk("ill_novalid", 32'(ex_illegal), 0);
        chk("rw_novalid", 32'(ex_reg_write), 0);

        // reset beats flush
        issue(1'b1, 2'b01, 6'b0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0);
        step();
        reset = 1'b1;  flush = 1'b1;
        step();
        chk("rst_over_flush_ctrl", 32'(alu_control), 0);
        chk("rst_over_flush_valid", 32'(ex_valid), 0);
        reset = 1'b0;  flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
